uart_byte_rx: RTL and testbench

UART receiver that deserialises 8N1-style frames from the asynchronous RX pin into parallel bytes. It is the receive counterpart of the existing uart_tx and sits in TOP between the uart_rx pin and downstream consumers such as the servo pulse-width path. Each received byte is presented with a one-cycle valid strobe. Framing errors and a busy status are reported for the control LEDs.

---
 rtl/uart_byte_rx.sv | 225 ++++++++++++++++++++++
 tb/tb_uart_byte_rx.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_byte_rx.sv
// UART receiver: 2-flop synchronised RX pin, mid-bit sampling, one-cycle valid/frame-error strobes.
// Optional parity checking is enabled by defining UART_RX_PARITY_EN (adds PARITY_ODD and o_uart_rx_parity_err).
module uart_byte_rx #(
    parameter int CLK_HZ       = 50_000_000,
    parameter int BIT_RATE     = 9600,
    parameter int PAYLOAD_BITS = 8,
    parameter int STOP_BITS    = 1
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD   = 1'b0
`endif
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_uart_rx_en,
    input  logic                    i_uart_rxd,
    output logic [PAYLOAD_BITS-1:0] o_uart_rx_data,
    output logic                    o_uart_rx_valid,
    output logic                    o_uart_rx_frame_err,
    output logic                    o_uart_rx_busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic                    o_uart_rx_parity_err
`endif
);

    // state     | meaning
    // IDLE      | line idle, waiting for a low rxd_s while enabled
    // START     | half a bit after the falling edge, confirm the start bit
    // DATA      | sample PAYLOAD_BITS data bits, LSB first
    // PARITY    | sample the parity bit (parity build only)
    // STOP      | sample STOP_BITS stop bits, then strobe valid or frame error
    // WAIT_IDLE | line stuck low after a bad stop bit, wait for it to go high

    localparam int CPB   = CLK_HZ / BIT_RATE;
    localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
    localparam int BIT_W = $clog2(PAYLOAD_BITS + 1);

    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CPB / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CPB - 1);
    localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(PAYLOAD_BITS - 1);
    localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_STOP      = 3'd4;
    localparam logic [2:0] S_WAIT_IDLE = 3'd5;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY    = 3'd3;
`endif

    logic                    rxd_meta;
    logic                    rxd_s;
    logic [2:0]              state,      state_nxt;
    logic [CNT_W-1:0]        cnt,        cnt_nxt;
    logic [BIT_W-1:0]        bit_idx,    bit_nxt;
    logic [PAYLOAD_BITS-1:0] shreg,      shreg_nxt;
    logic                    stop_bad,   stop_bad_nxt;
    logic [PAYLOAD_BITS-1:0] data_nxt;
    logic                    valid_nxt;
    logic                    ferr_nxt;
    logic                    tick;
    logic                    stop_bad_now;
`ifdef UART_RX_PARITY_EN
    logic                    par_acc,    par_acc_nxt;
    logic                    par_bad,    par_bad_nxt;
    logic                    perr_nxt;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
        end else begin
            rxd_meta <= i_uart_rxd;
            rxd_s    <= rxd_meta;
        end
    end

    // Bit timer is a down-counter; every sample happens on its terminal count.
    assign tick         = (cnt == '0);
    assign stop_bad_now = stop_bad | ~rxd_s;

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        bit_nxt      = bit_idx;
        shreg_nxt    = shreg;
        stop_bad_nxt = stop_bad;
        data_nxt     = o_uart_rx_data;
        valid_nxt    = 1'b0;
        ferr_nxt     = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_acc_nxt  = par_acc;
        par_bad_nxt  = par_bad;
        perr_nxt     = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (!rxd_s && i_uart_rx_en) begin
                    state_nxt    = S_START;
                    cnt_nxt      = HALF_LOAD;
                    bit_nxt      = '0;
                    stop_bad_nxt = 1'b0;
`ifdef UART_RX_PARITY_EN
                    par_acc_nxt  = 1'b0;
                    par_bad_nxt  = 1'b0;
`endif
                end
            end
            S_START: begin
                if (!tick) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end else if (rxd_s) begin
                    state_nxt = S_IDLE;
                end else begin
                    state_nxt = S_DATA;
                    cnt_nxt   = BIT_LOAD;
                end
            end
            S_DATA: begin
                if (!tick) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end else begin
                    cnt_nxt   = BIT_LOAD;
                    shreg_nxt = {rxd_s, shreg[PAYLOAD_BITS-1:1]};
`ifdef UART_RX_PARITY_EN
                    par_acc_nxt = par_acc ^ rxd_s;
`endif
                    if (bit_idx == LAST_DATA) begin
                        bit_nxt = '0;
`ifdef UART_RX_PARITY_EN
                        state_nxt = S_PARITY;
`else
                        state_nxt = S_STOP;
`endif
                    end else begin
                        bit_nxt = bit_idx + BIT_W'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (!tick) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end else begin
                    cnt_nxt     = BIT_LOAD;
                    par_bad_nxt = ((par_acc ^ rxd_s) != PARITY_ODD);
                    state_nxt   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (!tick) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end else if (bit_idx != LAST_STOP) begin
                    cnt_nxt      = BIT_LOAD;
                    bit_nxt      = bit_idx + BIT_W'(1);
                    stop_bad_nxt = stop_bad_now;
                end else if (stop_bad_now) begin
                    ferr_nxt  = 1'b1;
                    state_nxt = S_WAIT_IDLE;
                end else begin
                    // Back to IDLE mid-stop-bit so an immediately following start bit is caught.
                    state_nxt = S_IDLE;
`ifdef UART_RX_PARITY_EN
                    if (par_bad) begin
                        perr_nxt = 1'b1;
                    end else begin
                        valid_nxt = 1'b1;
                        data_nxt  = shreg;
                    end
`else
                    valid_nxt = 1'b1;
                    data_nxt  = shreg;
`endif
                end
            end
            S_WAIT_IDLE: begin
                if (rxd_s) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state               <= S_IDLE;
            cnt                 <= '0;
            bit_idx             <= '0;
            shreg               <= '0;
            stop_bad            <= 1'b0;
            o_uart_rx_data      <= '0;
            o_uart_rx_valid     <= 1'b0;
            o_uart_rx_frame_err <= 1'b0;
            o_uart_rx_busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_acc             <= 1'b0;
            par_bad             <= 1'b0;
            o_uart_rx_parity_err <= 1'b0;
`endif
        end else begin
            state               <= state_nxt;
            cnt                 <= cnt_nxt;
            bit_idx             <= bit_nxt;
            shreg               <= shreg_nxt;
            stop_bad            <= stop_bad_nxt;
            o_uart_rx_data      <= data_nxt;
            o_uart_rx_valid     <= valid_nxt;
            o_uart_rx_frame_err <= ferr_nxt;
            o_uart_rx_busy      <= (state_nxt != S_IDLE);
`ifdef UART_RX_PARITY_EN
            par_acc             <= par_acc_nxt;
            par_bad             <= par_bad_nxt;
            o_uart_rx_parity_err <= perr_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_uart_byte_rx.sv
// Self-checking bench for uart_byte_rx: frame-level timing model plus directed and random frames.
// Exercises the parity option too when UART_RX_PARITY_EN is defined (even parity).
module tb_uart_byte_rx;

    localparam int CLK_HZ   = 1_000_000;
    localparam int BIT_RATE = 100_000;
    localparam int CPB      = 10;
`ifdef UART_RX_PARITY_EN
    localparam int NB       = 9;
    localparam int LAT_LIT  = 108;
`else
    localparam int NB       = 8;
    localparam int LAT_LIT  = 98;
`endif
    localparam int FRAME_LEN = (NB + 2) * CPB;
    // Two sync flops, half a bit to the start sample, NB+1 bits to the stop sample, one register stage.
    localparam int VAL_OFS   = 2 + CPB / 2 + (NB + 1) * CPB + 1;

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_uart_rx_en = 1'b1;
    logic       i_uart_rxd = 1'b1;
    logic [7:0] o_uart_rx_data;
    logic       o_uart_rx_valid;
    logic       o_uart_rx_frame_err;
    logic       o_uart_rx_busy;
`ifdef UART_RX_PARITY_EN
    logic       o_uart_rx_parity_err;
`endif

    uart_byte_rx #(
        .CLK_HZ      (CLK_HZ),
        .BIT_RATE    (BIT_RATE),
        .PAYLOAD_BITS(8),
        .STOP_BITS   (1)
    ) dut (
        .i_clk              (i_clk),
        .i_reset            (i_reset),
        .i_uart_rx_en       (i_uart_rx_en),
        .i_uart_rxd         (i_uart_rxd),
        .o_uart_rx_data     (o_uart_rx_data),
        .o_uart_rx_valid    (o_uart_rx_valid),
        .o_uart_rx_frame_err(o_uart_rx_frame_err),
        .o_uart_rx_busy     (o_uart_rx_busy)
`ifdef UART_RX_PARITY_EN
        ,
        .o_uart_rx_parity_err(o_uart_rx_parity_err)
`endif
    );

    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    bit         checking = 1'b0;
    bit         exp_valid[int];
    logic [7:0] exp_vdata[int];
    bit         exp_ferr[int];
    bit         exp_perr[int];
    bit         exp_busy[int];
    bit         exp_rst[int];
    logic [7:0] mdata = 8'h00;
    int         n_valid = 0;
    int         n_ferr = 0;
    int         n_perr = 0;
    int         last_valid_cyc = -1;
    logic [7:0] last_valid_data = 8'h00;

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge i_clk) begin
        if (checking) begin
            if (exp_rst.exists(cyc)) mdata = 8'h00;
            if (exp_valid.exists(cyc)) mdata = exp_vdata[cyc];
            check("valid", {31'd0, o_uart_rx_valid}, exp_valid.exists(cyc));
            check("frame_err", {31'd0, o_uart_rx_frame_err}, exp_ferr.exists(cyc));
            check("busy", {31'd0, o_uart_rx_busy}, exp_busy.exists(cyc));
            check("data", {24'd0, o_uart_rx_data}, {24'd0, mdata});
`ifdef UART_RX_PARITY_EN
            check("parity_err", {31'd0, o_uart_rx_parity_err}, exp_perr.exists(cyc));
            if (o_uart_rx_parity_err) n_perr++;
`endif
            if (o_uart_rx_valid) begin
                n_valid++;
                last_valid_cyc  = cyc;
                last_valid_data = o_uart_rx_data;
            end
            if (o_uart_rx_frame_err) n_ferr++;
        end
    end

    task automatic mark_busy(input int a, input int b);
        for (int c = a; c <= b; c++) exp_busy[c] = 1'b1;
    endtask

    task automatic idle(input int n);
        i_uart_rxd = 1'b1;
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    // Drives one frame starting now; the model expectations are registered up front.
    task automatic send_frame(input logic [7:0] d, input bit stop_ok, input int extra_low,
                              input bit par_flip, input bit en_off, input bit en_drop);
        int   e;
        int   vc;
        int   h;
        bit   perr_exp;
        logic bits[$];
        e  = cyc;
        vc = e + VAL_OFS;
        perr_exp = 1'b0;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
`ifdef UART_RX_PARITY_EN
        bits.push_back((^d) ^ par_flip);
        perr_exp = par_flip;
`endif
        bits.push_back(stop_ok);
        if (!en_off) begin
            if (!stop_ok) begin
                h = e + FRAME_LEN + extra_low;
                exp_ferr[vc] = 1'b1;
                mark_busy(e + 3, h + 2);
            end else begin
                mark_busy(e + 3, vc - 1);
                if (perr_exp) begin
                    exp_perr[vc] = 1'b1;
                end else begin
                    exp_valid[vc] = 1'b1;
                    exp_vdata[vc] = d;
                end
            end
        end
        if (en_off) i_uart_rx_en = 1'b0;
        foreach (bits[i]) begin
            i_uart_rxd = bits[i];
            if (en_drop && i == 4) i_uart_rx_en = 1'b0;
            repeat (CPB) @(posedge i_clk);
            #1;
        end
        if (!stop_ok) begin
            repeat (extra_low) begin
                @(posedge i_clk);
                #1;
            end
            idle(1);
        end
        i_uart_rx_en = 1'b1;
    endtask

    int         e0;
    int         nv;
    int         nf;
    int         np;
    int         nbusy;
    logic [7:0] rd;
    int         r;
    bit         sok;
    bit         pf;
    int         ext;

    initial begin
        repeat (2) begin
            @(posedge i_clk);
            #1;
        end
        checking = 1'b1;
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        idle(5);

        // Single good frame: latency and data pinned with literals.
        nv = n_valid;
        e0 = cyc;
        send_frame(8'h41, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        idle(3);
        check("t1_count", n_valid - nv, 1);
        check("t1_latency", last_valid_cyc - e0, LAT_LIT);
        check("t1_data", {24'd0, last_valid_data}, 32'h41);

        // Back-to-back with zero idle gap.
        nv = n_valid;
        nf = n_ferr;
        send_frame(8'h55, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        send_frame(8'hAA, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        idle(3);
        check("b2b_count", n_valid - nv, 2);
        check("b2b_last", {24'd0, last_valid_data}, 32'hAA);
        check("b2b_ferr", n_ferr - nf, 0);

        // Three-cycle glitch: busy for five cycles, no strobes.
        idle(10);
        nv = n_valid;
        nf = n_ferr;
        nbusy = 0;
        e0 = cyc;
        mark_busy(e0 + 3, e0 + 7);
        i_uart_rxd = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge i_clk);
            if (o_uart_rx_busy) nbusy++;
            @(posedge i_clk);
            #1;
            if (i == 2) i_uart_rxd = 1'b1;
        end
        check("glitch_busy_cycles", nbusy, 5);
        check("glitch_valid", n_valid - nv, 0);
        check("glitch_ferr", n_ferr - nf, 0);

        // Bad stop bit followed by a stuck-low line.
        nv = n_valid;
        nf = n_ferr;
        send_frame(8'hFF, 1'b0, 50, 1'b0, 1'b0, 1'b0);
        idle(5);
        check("ferr_count", n_ferr - nf, 1);
        check("ferr_valid", n_valid - nv, 0);
        check("ferr_data_held", {24'd0, o_uart_rx_data}, 32'hAA);

        // Reset during bit 3 of 0x33 (line released at the same time).
        idle(10);
        nv = n_valid;
        e0 = cyc;
        mark_busy(e0 + 3, e0 + 44);
        exp_rst[e0 + 45] = 1'b1;
        i_uart_rxd = 1'b0;
        repeat (CPB) @(posedge i_clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            i_uart_rxd = (i < 2);
            repeat (CPB) @(posedge i_clk);
            #1;
        end
        i_uart_rxd = 1'b0;
        repeat (4) @(posedge i_clk);
        #1;
        i_reset    = 1'b1;
        i_uart_rxd = 1'b1;
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        check("rst_data", {24'd0, o_uart_rx_data}, 32'h0);
        check("rst_busy", {31'd0, o_uart_rx_busy}, 32'h0);
        idle(20);
        check("rst_no_strobe", n_valid - nv, 0);
        send_frame(8'h33, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        idle(3);
        check("rst_next_data", {24'd0, last_valid_data}, 32'h33);

        // Disabled receiver ignores a whole frame; mid-frame disable does not abort.
        nv = n_valid;
        send_frame(8'h5A, 1'b1, 0, 1'b0, 1'b1, 1'b0);
        idle(3);
        check("en_off_valid", n_valid - nv, 0);
        send_frame(8'hC3, 1'b1, 0, 1'b0, 1'b0, 1'b1);
        idle(3);
        check("en_drop_data", {24'd0, last_valid_data}, 32'hC3);

`ifdef UART_RX_PARITY_EN
        nv = n_valid;
        np = n_perr;
        send_frame(8'h07, 1'b1, 0, 1'b1, 1'b0, 1'b0);
        idle(3);
        check("par_bad_count", n_perr - np, 1);
        check("par_bad_valid", n_valid - nv, 0);
        send_frame(8'h07, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        idle(3);
        check("par_ok_count", n_valid - nv, 1);
        check("par_ok_data", {24'd0, last_valid_data}, 32'h07);
`else
        np = n_perr;
`endif

        // Random frames: good, bad stop, disabled, mid-frame disable, random gaps.
        for (int k = 0; k < 24; k++) begin
            rd  = 8'($urandom);
            r   = int'($urandom_range(0, 99));
            sok = (r >= 15);
            ext = int'($urandom_range(0, 30));
            pf  = 1'b0;
`ifdef UART_RX_PARITY_EN
            pf  = sok && ($urandom_range(0, 4) == 0);
`endif
            send_frame(rd, sok, ext, pf, (r >= 15 && r < 25), (r >= 25 && r < 40));
            idle(int'($urandom_range(0, 12)));
        end
        idle(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
